// File: rtl/hazard_stall_ctrl.sv
// Purpose: load-use and matrix-in-flight hazard detector; freezes PC/IF-ID and bubbles ID/EX. Optional stall counter under HAZARD_STATS_EN.
// Latency: stall outputs are combinational in the hazard cycle; matrix busy/timeout state updates on the next rising edge.
// Backpressure: a matrix stall holds until the mat_done cycle, or until MAT_LAT cycles pass and the op times out.
module hazard_stall_ctrl #(
    parameter int MAT_LAT = 4,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_rs2_r_select,
    input  logic              id_is_mat,
    input  logic [4:0]        ex_rd,
    input  logic              ex_mem_read,
    input  logic [1:0]        ex_w_select,
    input  logic              mat_done,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              flush_id_ex,
    output logic              mat_busy,
    output logic              mat_timeout,
    output logic [STAT_W-1:0] stall_cycles
);

    typedef enum logic {
        IDLE    = 1'b0,
        MAT_RUN = 1'b1
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MAT_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       timeout_set;
    logic       lu;
    logic       mh;
    logic       stall;
    logic       issue;

    // Hazard detection; only scalar loads need a bubble, matrix writebacks are forwarded.
    always_comb begin
        lu = ex_mem_read && (ex_w_select == 2'b01) && (ex_rd != 5'd0) && id_valid &&
             ((id_rs1_used && (ex_rd == id_rs1)) ||
              (id_rs2_used && id_rs2_r_select && (ex_rd == id_rs2)));
        mh = (state == MAT_RUN) && !mat_done && id_valid &&
             (id_is_mat || (id_rs2_used && !id_rs2_r_select));
        stall = rstn && (lu || mh);
        issue = id_valid && id_is_mat && !stall;
    end

    assign stall_pc    = stall;
    assign stall_if_id = stall;
    assign flush_id_ex = stall;
    assign mat_busy    = (state == MAT_RUN);

    // Next-state: track one matrix op in flight, allow re-issue on the completion cycle.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt = MAT_RUN;
                    cnt_nxt   = CNT_INIT;
                end
            end
            MAT_RUN: begin
                if (mat_done) begin
                    if (issue) begin
                        cnt_nxt = CNT_INIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (cnt == 4'd0) begin
                    state_nxt   = IDLE;
                    timeout_set = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; the timeout flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            mat_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            mat_timeout <= mat_timeout | timeout_set;
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {STAT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + STAT_W'(1);
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule
